// File: rtl/serial_mult_ctrl_if.sv
// Handshake and data bundle between a requester and the serial shift-and-add multiplier.
interface serial_mult_ctrl_if #(
    parameter int N = 4
);
    logic           Start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic [2*N-1:0] P;
    logic           Busy;
    logic           Done;

    modport master (
        output Start, A, B,
        input  P, Busy, Done
    );

    modport slave (
        input  Start, A, B,
        output P, Busy, Done
    );
endinterface

// File: rtl/serial_mult_ctrl.sv
// Shift-and-add unsigned multiplier: consumes one multiplier bit per clock, N steps per product.
module serial_mult_ctrl #(
    parameter int N = 4
) (
    input  logic             CLK,
    input  logic             RST,
    serial_mult_ctrl_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [2*N-1:0] acc_sum;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        p_d      = p_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            // DONE accepts a new request exactly like IDLE so back-to-back starts lose no cycle
            IDLE, DONE: begin
                if (bus.Start) begin
                    mcand_d  = {{N{1'b0}}, bus.A};
                    mplier_d = bus.B;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    p_d     = acc_sum;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.P    = p_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Directed and swept checks of serial_mult_ctrl against a cycle model with a product scoreboard.
module tb_serial_mult_ctrl;
    localparam int N  = 4;
    localparam int N8 = 8;

    logic CLK = 1'b0;
    logic RST;

    serial_mult_ctrl_if #(.N(N))  bus  ();
    serial_mult_ctrl_if #(.N(N8)) bus8 ();

    serial_mult_ctrl #(.N(N))  dut  (.CLK(CLK), .RST(RST), .bus(bus));
    serial_mult_ctrl #(.N(N8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));

    always #5 CLK = ~CLK;

    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

    logic [2*N-1:0] sb[$];
    mstate_t        mstate = M_IDLE;
    int             mcnt   = 0;
    logic [2*N-1:0] mp     = '0;
    int             cmps   = 0;
    int             errs   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmps++;
        assert (obs === exp)
        else begin
            errs++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample what the DUT will see, advance, update the model, compare.
    task automatic step();
        logic           s, r;
        logic [N-1:0]   a, b;
        logic [2*N-1:0] expp;
        s = bus.Start;
        r = RST;
        a = bus.A;
        b = bus.B;
        @(posedge CLK);
        #1;
        if (r) begin
            mstate = M_IDLE;
            mcnt   = 0;
            mp     = '0;
            sb.delete();
        end else begin
            case (mstate)
                M_IDLE, M_DONE: begin
                    if (s) begin
                        sb.push_back({{N{1'b0}}, a} * {{N{1'b0}}, b});
                        mstate = M_RUN;
                        mcnt   = 0;
                    end else begin
                        mstate = M_IDLE;
                    end
                end
                M_RUN: begin
                    if (mcnt == N - 1) mstate = M_DONE;
                    else               mcnt++;
                end
                default: mstate = M_IDLE;
            endcase
        end
        if (mstate == M_DONE && sb.size() > 0) begin
            expp = sb.pop_front();
            checkOutput("product", bus.P, expp);
            mp = expp;
        end
        checkOutput("busy", bus.Busy, (mstate == M_RUN));
        checkOutput("done", bus.Done, (mstate == M_DONE));
        checkOutput("p_hold", bus.P, mp);
    endtask

    task automatic applyStimulus(input int a, input int b);
        bus.A     = N'(a);
        bus.B     = N'(b);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    initial begin
        int n;
        RST        = 1'b1;
        bus.Start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus8.Start = 1'b0;
        bus8.A     = '0;
        bus8.B     = '0;
        step();
        step();
        RST = 1'b0;
        checkOutput("reset_p", bus.P, 0);
        checkOutput("reset_busy", bus.Busy, 0);

        $display("[TB] basic 5x3");
        applyStimulus(5, 3);
        repeat (N) step();
        checkOutput("p_5x3", bus.P, 8'h0F);
        repeat (3) step();
        checkOutput("p_5x3_hold", bus.P, 8'h0F);

        $display("[TB] corner operands");
        applyStimulus(15, 15);
        repeat (N + 1) step();
        checkOutput("p_15x15", bus.P, 8'hE1);
        applyStimulus(0, 9);
        repeat (N + 1) step();
        checkOutput("p_0x9", bus.P, 8'h00);
        applyStimulus(9, 0);
        repeat (N + 1) step();

        $display("[TB] start during run ignored");
        applyStimulus(6, 7);
        step();
        bus.A     = 4'd1;
        bus.B     = 4'd1;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        repeat (N) step();
        checkOutput("p_6x7", bus.P, 8'h2A);

        $display("[TB] start held high");
        bus.A     = 4'd2;
        bus.B     = 4'd3;
        bus.Start = 1'b1;
        step();
        repeat (N) step();
        checkOutput("p_2x3", bus.P, 8'd6);
        bus.A = 4'd4;
        bus.B = 4'd4;
        step();
        repeat (N) step();
        checkOutput("p_4x4", bus.P, 8'd16);
        bus.Start = 1'b0;
        step();
        step();

        $display("[TB] reset mid-run");
        applyStimulus(7, 5);
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        checkOutput("abort_p", bus.P, 0);
        repeat (N + 2) step();
        applyStimulus(3, 3);
        repeat (N + 1) step();
        checkOutput("p_3x3", bus.P, 8'd9);

        $display("[TB] full sweep N=4");
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                applyStimulus(ia, ib);
                repeat (N) step();
            end
        end
        step();
        step();

        $display("[TB] sampled pairs N=8");
        for (int k = 0; k < 10; k++) begin
            logic [N8-1:0] x, y;
            x = (k == 0) ? 8'hFF : N8'($urandom_range(0, 255));
            y = (k == 0) ? 8'hFF : N8'($urandom_range(0, 255));
            bus8.A     = x;
            bus8.B     = y;
            bus8.Start = 1'b1;
            step();
            bus8.Start = 1'b0;
            n = 0;
            while (bus8.Done !== 1'b1 && n < 3 * N8) begin
                step();
                n++;
            end
            if (bus8.Done !== 1'b1) begin
                checkOutput("done8_timeout", bus8.Done, 1);
            end else begin
                checkOutput("p8", bus8.P, 64'(x) * 64'(y));
                checkOutput("lat8", n, N8);
            end
            step();
            checkOutput("done8_width", bus8.Done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
